// File: rtl/mem_stage_bw.sv
// MEM stage data memory: byte/half/word loads and stores, fault flags, store counter.
// Optional store log when DM_WRITE_LOG_EN is defined.
module mem_stage_bw #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] rd2,
  input  logic [31:0] wd_wb,
  input  logic        wd_sel,
  input  logic [31:0] pc,
  input  logic        re,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        load_signed,
  output logic [31:0] read_data,
  output logic        addr_err,
  output logic        err_sticky,
  output logic [15:0] store_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] off;
  logic [29:0] widx;
  logic [AW-1:0] idx;
  logic        oob, mis, commit;
  logic [31:0] sd, old, merged, ld;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign off  = addr - BASE_ADDR;
  assign widx = off[31:2];
  assign idx  = widx[AW-1:0];
  assign oob  = widx >= 30'(DEPTH);
  assign old  = mem_q[idx];
  assign sd   = wd_sel ? wd_wb : rd2;
  assign lb   = old[{addr[1:0], 3'b000} +: 8];
  assign lh   = addr[1] ? old[31:16] : old[15:0];

  always_comb begin
    mis = 1'b0;
    case (size)
      2'b00:   mis = addr[1:0] != 2'b00;
      2'b01:   mis = addr[0];
      2'b10:   mis = 1'b0;
      default: mis = 1'b1;
    endcase
  end

  assign addr_err = (re | we) & (oob | mis);
  assign commit   = we & ~addr_err & ~reset;

  always_comb begin
    merged = old;
    ld     = old;
    case (size)
      2'b00: merged = sd;
      2'b01: begin
        merged[{addr[1], 4'b0000} +: 16] = sd[15:0];
        ld = {{16{load_signed & lh[15]}}, lh};
      end
      2'b10: begin
        merged[{addr[1:0], 3'b000} +: 8] = sd[7:0];
        ld = {{24{load_signed & lb[7]}}, lb};
      end
      default: ld = 32'h0;
    endcase
  end

  assign read_data = (re & ~addr_err) ? ld : 32'h0;

  always_comb begin
    cnt_d = cnt_q + 16'(commit);
    err_d = err_q | addr_err;
  end

  // Whole array clears in the reset cycle, so it is kept in flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      cnt_q <= 16'h0;
      err_q <= 1'b0;
    end else begin
      if (commit) mem_q[idx] <= merged;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign store_cnt  = cnt_q;
  assign err_sticky = err_q;

`ifdef DM_WRITE_LOG_EN
  logic [1:0] unused_off;
  assign unused_off = off[1:0];

  always_ff @(posedge clk) begin
    if (commit)
      $display("%0t@%h: *%h <= %h", $time, pc,
               {addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^{pc, off[1:0]};
`endif
endmodule

// File: tb/tb_mem_stage_bw.sv
// Directed bench for mem_stage_bw with hand-computed expectations.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_mem_stage_bw;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, rd2, wd_wb, pc;
  logic        wd_sel, re, we, load_signed;
  logic [1:0]  size;
  logic [31:0] read_data;
  logic        addr_err, err_sticky;
  logic [15:0] store_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_bw dut (
    .clk(clk), .reset(reset), .addr(addr), .rd2(rd2),
    .wd_wb(wd_wb), .wd_sel(wd_sel), .pc(pc), .re(re),
    .we(we), .size(size), .load_signed(load_signed),
    .read_data(read_data), .addr_err(addr_err),
    .err_sticky(err_sticky), .store_cnt(store_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    re = 0; we = 0; wd_sel = 0; size = 2'b00;
    load_signed = 0; rd2 = 0; wd_wb = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s,
                      input logic sg);
    idle();
    re = 1; addr = a; size = s; load_signed = sg;
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d);
    idle();
    we = 1; addr = a; size = s; rd2 = d;
    tick();
    idle();
  endtask

  initial begin
    idle();
    addr = 0; pc = 32'h100; reset = 1;
    tick();
    reset = 0;
    load(32'h10, 2'b00, 0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_cnt", 32'(store_cnt), 32'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);

    store(32'h10, 2'b00, 32'hDEADBEEF); exp_cnt++;
    load(32'h10, 2'b00, 0);
    chk("word_ld", read_data, 32'hDEADBEEF);
    chk("cnt1", 32'(store_cnt), 32'd1);

    store(32'h11, 2'b10, 32'h55); exp_cnt++;
    load(32'h10, 2'b00, 0);
    chk("byte_merge", read_data, 32'hDEAD55EF);
    load(32'h13, 2'b10, 1);
    chk("byte_s", read_data, 32'hFFFFFFDE);
    load(32'h13, 2'b10, 0);
    chk("byte_u", read_data, 32'h000000DE);

    idle();
    we = 1; addr = 32'h12; size = 2'b01;
    wd_sel = 1; wd_wb = 32'h00008001; rd2 = 0;
    tick(); exp_cnt++;
    load(32'h10, 2'b00, 0);
    chk("half_merge", read_data, 32'h800155EF);
    load(32'h12, 2'b01, 1);
    chk("half_s", read_data, 32'hFFFF8001);
    load(32'h10, 2'b01, 1);
    chk("half_lo_s", read_data, 32'h000055EF);
    chk("no_err", 32'(addr_err), 32'h0);
    chk("sticky0", 32'(err_sticky), 32'h0);

    load(32'h11, 2'b00, 0);
    chk("mis_err", 32'(addr_err), 32'h1);
    chk("mis_rdata", read_data, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("sticky1", 32'(err_sticky), 32'h1);

    idle();
    we = 1; addr = 32'h1000; rd2 = 32'hCAFEF00D;
    @(negedge clk);
    chk("oob_err", 32'(addr_err), 32'h1);
    tick();
    load(32'h0, 2'b00, 0);
    chk("oob_nowrite", read_data, 32'h0);
    chk("oob_cnt", 32'(store_cnt), 32'(exp_cnt));
    load(32'h10, 2'b11, 0);
    chk("size11_err", 32'(addr_err), 32'h1);
    load(32'h11, 2'b01, 0);
    chk("half_mis", 32'(addr_err), 32'h1);
    load(32'h13, 2'b10, 0);
    chk("byte_ok", 32'(addr_err), 32'h0);

    store(32'h20, 2'b00, 32'hAAAAAAAA); exp_cnt++;
    idle();
    re = 1; we = 1; addr = 32'h20; rd2 = 32'h12345678;
    @(negedge clk);
    chk("rw_old", read_data, 32'hAAAAAAAA);
    tick(); exp_cnt++;
    load(32'h20, 2'b00, 0);
    chk("rw_new", read_data, 32'h12345678);
    idle();
    addr = 32'h20;
    @(negedge clk);
    chk("re0_zero", read_data, 32'h0);
    chk("cnt5", 32'(store_cnt), 32'(exp_cnt));

    idle();
    we = 1; addr = 32'h40;
    for (int i = exp_cnt; i < 65536; i++) begin
      rd2 = i;
      tick();
    end
    idle();
    @(negedge clk);
    chk("cnt_wrap", 32'(store_cnt), 32'h0);

    idle();
    reset = 1; we = 1; addr = 32'h10; rd2 = 32'hFFFFFFFF;
    tick();
    reset = 0;
    load(32'h10, 2'b00, 0);
    chk("rst_w10", read_data, 32'h0);
    load(32'h20, 2'b00, 0);
    chk("rst_w20", read_data, 32'h0);
    load(32'h40, 2'b00, 0);
    chk("rst_w40", read_data, 32'h0);
    chk("rst_cnt2", 32'(store_cnt), 32'h0);
    chk("rst_sticky2", 32'(err_sticky), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_bw.md
MEM_STAGE_BW -- requirements
Module: mem_stage_bw

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, data memory size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  32  byte address (ALU result of MEM stage).
REQ-006 SHALL have port rd2  input  32  store data from register file path.
REQ-007 SHALL have port wd_wb  input  32  store data forwarded from WB stage.
REQ-008 SHALL have port wd_sel  input  1  store data source: 0 = rd2, 1 = wd_wb.
REQ-009 SHALL have port pc  input  32  PC of the instruction in MEM; used only for the write log.
REQ-010 SHALL have port re  input  1  load request.
REQ-011 SHALL have port we  input  1  store request.
REQ-012 SHALL have port size  input  2  access width: 00 word, 01 half, 10 byte, 11 illegal.
REQ-013 SHALL have port load_signed  input  1  1 = sign-extend half/byte loads, 0 = zero-extend.
REQ-014 SHALL have port read_data  output  32  load result.
REQ-015 SHALL have port addr_err  output  1  current access faulting (combinational).
REQ-016 SHALL have port err_sticky  output  1  latched fault flag.
REQ-017 SHALL have port store_cnt  output  16  count of committed stores.

Function
REQ-018 SHALL compute offset = addr - BASE_ADDR; word index = offset[31:2].
REQ-019 SHALL assert addr_err when (re|we) and any of: word index >= DEPTH; size=11; size=00 with addr[1:0]!=0; size=01 with addr[0]!=0; else 0.
REQ-020 SHALL commit a store on rising edge when we=1, addr_err=0, reset=0; no other condition writes the array.
REQ-021 SHALL take store data from wd_wb when wd_sel=1, else rd2.
REQ-022 SHALL write word: all 4 lanes; half: bits[15:0] into lanes {addr[1],0} and {addr[1],1}; byte: bits[7:0] into lane addr[1:0]; untouched lanes keep old value; lane 0 = bits[7:0].
REQ-023 SHALL produce read_data combinationally in the same cycle from array contents before any same-cycle store (store and load same address same cycle: load returns old data).
REQ-024 SHALL extract the addressed half/byte lane and extend per load_signed; word loads unaltered.
REQ-025 SHALL drive read_data = 0 when re=0 or addr_err=1.
REQ-026 SHALL increment store_cnt by 1 per committed store, wrapping 16'hFFFF -> 16'h0000.
REQ-027 SHALL set err_sticky on rising edge after any cycle with addr_err=1; it clears only on reset.
REQ-028 SHALL treat re and we both 1 as a valid combined access (load old data, commit store).

Reset
REQ-029 SHALL, on rising edge with reset=1, clear every array word to 0, store_cnt to 0, err_sticky to 0, in that single cycle.
REQ-030 SHALL suppress any store presented while reset=1 (no write, no count, no log line).
REQ-031 SHALL output read_data = 0 in the cycle after reset for any valid load.

Configuration
REQ-032 SHALL, with macro DM_WRITE_LOG_EN defined, print one line per committed store: "<time>@<pc hex>: *<word byte-address hex> <= <merged 32-bit word hex>".
REQ-033 SHALL, without DM_WRITE_LOG_EN, print nothing; all port behaviour identical.

Verification
REQ-034 SHALL cover: reset; we=1,size=00,addr=0x10,rd2=0xDEADBEEF -> next cycle load word 0x10 returns 0xDEADBEEF, store_cnt=1.
REQ-035 SHALL cover: after REQ-034, byte store 0x11 data 0x55 then load word 0x10 -> 0xDEAD55EF; byte load 0x13 signed -> 0xFFFFFFDE, unsigned -> 0x000000DE.
REQ-036 SHALL cover: half store 0x12 with wd_sel=1, wd_wb=0x00008001, rd2=0 -> word 0x10 reads 0x800155EF; signed half load 0x12 -> 0xFFFF8001.
REQ-037 SHALL cover: word load at 0x11 -> addr_err=1, read_data=0, err_sticky=1 next cycle; store at DEPTH*4 -> no write, store_cnt unchanged.
REQ-038 SHALL cover: same-cycle store 0x12345678 and load at 0x20 (held 0xAAAAAAAA) -> read_data 0xAAAAAAAA, next cycle 0x12345678.
REQ-039 SHALL cover: 65536 stores -> store_cnt wraps to 0; reset with we=1 -> array zero, counters zero, no log line.
